// File: rtl/amem_readout_seq_if.sv
// Handshake and data bundle between the APP analog-memory readout
// sequencer and its surrounding measurement / readout logic.
interface amem_readout_seq_if #(
  parameter int TS_WIDTH = 64
);
  logic                tot;
  logic [7:0]          metadata;
  logic                circular_en;
  logic                read_next;
  logic                adc_ready;
  logic                adc_done;
  logic                reset_pingpong;
  logic                read_en;
  logic [2:0]          event_mux;
  logic [TS_WIDTH-1:0] ts_out;
  logic [7:0]          meta_out;
  logic                out_valid;
  logic                amem_empty;
  logic                amem_full;
  logic [7:0]          lost_count;

  modport master (
    output tot, metadata, circular_en,
    output read_next, adc_ready, adc_done,
    input  reset_pingpong, read_en, event_mux,
    input  ts_out, meta_out, out_valid,
    input  amem_empty, amem_full, lost_count
  );

  modport slave (
    input  tot, metadata, circular_en,
    input  read_next, adc_ready, adc_done,
    output reset_pingpong, read_en, event_mux,
    output ts_out, meta_out, out_valid,
    output amem_empty, amem_full, lost_count
  );
endinterface

// File: rtl/amem_readout_seq.sv
// Readout sequencer for the 8-column APP analog memory: TOT edges
// fill an 8-entry timestamp FIFO, read_next drains it column by column.
module amem_readout_seq #(
  parameter int TS_WIDTH      = 64,
  parameter int SETTLE_CYCLES = 2
) (
  input logic clk,
  input logic resetb_full,
  amem_readout_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    WAIT_ADC,
    CONVERT,
    DONE
  } state_t;

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [7:0]          meta;
  } entry_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);

  logic [TS_WIDTH-1:0] ts_q;
  logic [7:0]          meta_q;
  logic                sync1;
  logic                sync2;
  logic                tot_prev;
  entry_t              mem [8];
  logic [2:0]          wr_ptr;
  logic [2:0]          rd_ptr;
  logic [3:0]          count;
  logic [3:0]          settle_cnt;
  state_t              state;

  logic tot_ev;
  logic full;
  logic do_pop;
  logic ovwr;
  logic do_wr;
  logic drop;
  logic inc;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  always_comb begin
    tot_ev = ~sync2 & tot_prev;
    full   = (count == 4'd8);
    do_pop = (state == CONVERT) & bus.adc_done;
    ovwr   = tot_ev & full & ~do_pop
           & bus.circular_en & (state == IDLE);
    do_wr  = tot_ev & (~full | do_pop | ovwr);
    drop   = tot_ev & ~do_wr;
    inc    = do_wr & ~ovwr;
  end

  always_ff @(posedge clk) begin
    if (!resetb_full) begin
      ts_q               <= '0;
      meta_q             <= '0;
      sync1              <= 1'b1;
      sync2              <= 1'b1;
      tot_prev           <= 1'b1;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      bus.lost_count     <= '0;
      bus.reset_pingpong <= 1'b0;
      bus.amem_empty     <= 1'b1;
      bus.amem_full      <= 1'b0;
    end else begin
      ts_q               <= ts_q + 1'b1;
      meta_q             <= bus.metadata;
      sync1              <= bus.tot;
      sync2              <= sync1;
      tot_prev           <= sync2;
      bus.reset_pingpong <= tot_ev;
      bus.amem_empty     <= (count == 4'd0);
      bus.amem_full      <= (count == 4'd8);
      if (do_wr)
        wr_ptr <= wr_ptr + 3'd1;
      if (do_pop || ovwr)
        rd_ptr <= rd_ptr + 3'd1;
      unique case (1'b1)
        (inc && !do_pop): count <= count + 4'd1;
        (do_pop && !inc): count <= count - 4'd1;
        default: ;
      endcase
      if (drop && bus.lost_count != 8'hFF)
        bus.lost_count <= bus.lost_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr] <= '{ts: ts_q, meta: meta_q};
  end

  always_ff @(posedge clk) begin
    if (!resetb_full) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      bus.read_en   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.event_mux <= '0;
      bus.ts_out    <= '0;
      bus.meta_out  <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          bus.read_en <= 1'b0;
          if (bus.read_next && count != 4'd0) begin
            bus.event_mux <= rd_ptr;
            settle_cnt    <= SETTLE_LD;
            state         <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == 4'd0)
            state <= WAIT_ADC;
          else
            settle_cnt <= settle_cnt - 4'd1;
        end
        WAIT_ADC: begin
          if (bus.adc_ready) begin
            bus.read_en <= 1'b1;
            state       <= CONVERT;
          end
        end
        CONVERT: begin
          if (bus.adc_done) begin
            bus.read_en   <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.ts_out    <= mem[rd_ptr].ts;
            bus.meta_out  <= mem[rd_ptr].meta;
            state         <= DONE;
          end
        end
        DONE: begin
          bus.read_en <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/amem_readout_seq.md
# amem_readout_seq

Readout sequencer for the 8-column APP analog memory. It turns synchronized falling edges of the analog TOT signal into write-pointer advances, and stores a timestamp plus 8-bit metadata per column in an internal 8-entry FIFO. On `read_next` requests it steps one column at a time through mux select, ADC handshake and read-enable. It sits between the APP analog measurement/memory circuitry and the external readout interface.

## Interface
- `TS_WIDTH`, 64, width of free-running timestamp counter and `ts_out`
- `SETTLE_CYCLES`, 2, cycles `event_mux` is held stable before ADC handshake (1..15)
- `clk`  in  1  system clock; all logic on rising edge
- `resetb_full`  in  1  synchronous, active-low reset
- `tot`  in  1  asynchronous analog TOT; event = falling edge
- `metadata`  in  8  event metadata, sampled every cycle
- `circular_en`  in  1  1 = overwrite oldest entry when full
- `read_next`  in  1  request readout of oldest column (level sampled in IDLE)
- `adc_ready`  in  1  ADC can start a conversion
- `adc_done`  in  1  ADC conversion complete
- `reset_pingpong`  out  1  1-cycle pulse per detected TOT event
- `read_en`  out  1  analog memory read enable
- `event_mux`  out  3  column select for read
- `ts_out`  out  TS_WIDTH  timestamp of column just read
- `meta_out`  out  8  metadata of column just read
- `out_valid`  out  1  1-cycle pulse; `ts_out`/`meta_out` valid
- `amem_empty`  out  1  count == 0
- `amem_full`  out  1  count == 8
- `lost_count`  out  8  saturating count of dropped events

## Operation
- Timestamp counter increments every cycle and wraps modulo 2^TS_WIDTH.
- `metadata` is registered each cycle into `meta_q`.
- TOT path: 2-flop synchronizer, then falling-edge detect (sync2 = 0, previous = 1) gives `tot_ev`, one cycle wide.
- On `tot_ev`:
  - `reset_pingpong` pulses the next cycle, always, even if the event is dropped.
  - Not full: write {timestamp, `meta_q`} at `wr_ptr`; `wr_ptr`++ (mod 8); count++.
  - Full with `circular_en` = 1 and FSM in IDLE: overwrite the entry at `wr_ptr` (== `rd_ptr`); both pointers advance; count stays 8.
  - Full otherwise: entry dropped; `lost_count`++, saturating at 255.
- FSM states:
  - IDLE: `read_en` = 0. If `read_next` && !empty, latch `event_mux` = `rd_ptr`, load settle counter, go to SETTLE. Otherwise `read_next` is ignored (not queued).
  - SETTLE: count down SETTLE_CYCLES cycles, then go to WAIT_ADC.
  - WAIT_ADC: wait for `adc_ready` = 1, then go to CONVERT.
  - CONVERT: `read_en` = 1; hold until `adc_done` = 1, then go to DONE.
  - DONE: `read_en` = 0; `out_valid` = 1 with the entry at `rd_ptr`; `rd_ptr`++; count--; next state IDLE.
- `event_mux` holds its value from SETTLE entry until the next SETTLE entry.
- Write and pop in the same cycle: both pointers move and count is unchanged. When full, the pop frees the slot first, so the event is stored, not dropped.
- `read_next` and `adc_*` are ignored outside their consuming state. An `adc_done` arriving early during WAIT_ADC is ignored.

## Timing
- Reset values, applied at the first rising edge with `resetb_full` = 0:
  - timestamp, pointers, count, `lost_count` = 0; FSM = IDLE.
  - `read_en`, `reset_pingpong`, `out_valid` = 0; `event_mux` = 0; `ts_out`, `meta_out` = 0.
  - `amem_empty` = 1, `amem_full` = 0.
  - Synchronizer flops reset to 1, so no spurious edge is seen out of reset.
- Reset mid-readout: `read_en` drops at that edge and FIFO contents are discarded.
- TOT latency: `tot` low before edge N gives `tot_ev` at edge N+2. Stored timestamp = counter value at edge N+2. `reset_pingpong` is high during cycle N+3.
- `amem_empty`/`amem_full` are registered and reflect count one cycle after an update.
- Readout latency from `read_next` sampled in IDLE at edge R, with `adc_ready` = 1 and an immediate `adc_done`:
  - SETTLE occupies R+1..R+SETTLE_CYCLES.
  - CONVERT is entered at R+SETTLE_CYCLES+2.
  - `out_valid` is high in the cycle after `adc_done` is sampled.
- Minimum spacing between TOT events is 2 cycles; closer edges merge.

## Test plan
- Reset, then 3 TOT falling edges at cycles 10, 20, 30 → `reset_pingpong` pulses at 13/23/33; count = 3, `amem_empty` = 0; stored timestamps 12, 22, 32.
- Drain 3 entries with `read_next`, `adc_ready` = 1, `adc_done` 2 cycles after `read_en` rises → `event_mux` 0, 1, 2; `out_valid` ×3 with timestamps 12/22/32; `amem_empty` = 1.
- 10 TOT events, `circular_en` = 0, no reads → `amem_full` = 1; `lost_count` = 2; readout returns events 1–8.
- Same stimulus with `circular_en` = 1 → `lost_count` = 0; readout returns events 3–10 starting at `event_mux` = 2.
- Full FIFO, TOT event in the same cycle as DONE → count stays 8, no drop, `out_valid` = 1.
- Reset asserted during CONVERT → `read_en` = 0 next edge; `amem_empty` = 1; `read_next` then ignored.
